// File: rtl/adder_sink_pkg.sv
// Shared defaults and helpers for the adder result sink.
// Holds the clog2 used for pointer/level widths and a width-agnostic saturating increment.
package adder_sink_pkg;

  localparam int unsigned DEF_DEPTH     = 8;
  localparam int unsigned DEF_CNT_WIDTH = 16;
  localparam int unsigned SAT_MAX_WIDTH = 64;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

  // The caller passes its all-ones mask, so one function serves every counter width.
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(input logic [SAT_MAX_WIDTH-1:0] value,
                                                       input logic [SAT_MAX_WIDTH-1:0] mask);
    return (value == mask) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/adder_sink_fifo.sv
// First-word-fall-through FIFO: storage, wrapping pointers and occupancy level.
// The head word reads as zero whenever the FIFO is empty.
module adder_sink_fifo
  import adder_sink_pkg::*;
#(
  parameter  int unsigned WIDTH = 34,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; stale words are never visible because the
  // read port is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  assign level = level_q;
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign rdata = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/adder_result_sink.sv
// Receive-side buffer for adder results: FIFO toward a stalling consumer plus overflow/drop stats.
// Optional macro ADDER_SINK_DROP_CNT_EN adds a saturating drop counter (otherwise drop_count is 0).
module adder_result_sink
  import adder_sink_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned DEPTH      = DEF_DEPTH,
  parameter  int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
  localparam int unsigned LVL_W      = ((DEPTH > 1) ? clog2(DEPTH) : 1) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_sum,
  input  logic                  in_cout,
  input  logic                  in_ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic [LVL_W-1:0]      level,
  output logic                  full,
  output logic                  empty,
  output logic                  drop_pulse,
  output logic [CNT_WIDTH-1:0]  ovf_count,
  output logic                  sticky_ovf,
  input  logic                  stat_clr,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam int unsigned          WORD_W  = DATA_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "adder_result_sink: DEPTH must be a power of two >= 2");
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > SAT_MAX_WIDTH) begin : g_bad_cnt
    $fatal(1, "adder_result_sink: CNT_WIDTH must be in 1..64");
  end

  logic              push, pop, drop, ovf_event;
  logic [WORD_W-1:0] head;

  logic                 drop_pulse_q;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
  logic                 sticky_q, sticky_d;

  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !out_ready;
  assign ovf_event = push && in_ovf;

  adder_sink_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_sum, in_cout, in_ovf}),
    .pop   (pop),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign out_valid                   = !empty;
  assign {out_sum, out_cout, out_ovf} = head;

  // Clear wins over history but not over an event in the same cycle.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    sticky_d  = sticky_q;
    if (stat_clr) begin
      ovf_cnt_d = CNT_WIDTH'(ovf_event);
      sticky_d  = ovf_event;
    end else if (ovf_event) begin
      ovf_cnt_d = CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(ovf_cnt_q), SAT_MAX_WIDTH'(CNT_MAX)));
      sticky_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_pulse_q <= 1'b0;
      ovf_cnt_q    <= '0;
      sticky_q     <= 1'b0;
    end else begin
      drop_pulse_q <= drop;
      ovf_cnt_q    <= ovf_cnt_d;
      sticky_q     <= sticky_d;
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign ovf_count  = ovf_cnt_q;
  assign sticky_ovf = sticky_q;

`ifdef ADDER_SINK_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (stat_clr)  drop_cnt_d = CNT_WIDTH'(drop);
    else if (drop) drop_cnt_d = CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(drop_cnt_q), SAT_MAX_WIDTH'(CNT_MAX)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_adder_result_sink.sv
// Self-checking bench for adder_result_sink: directed scenarios then random traffic,
// all compared against a queue-based reference model (16-bit and 2-bit counter instances).
module tb_adder_result_sink;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_cout, in_ovf, out_ready, stat_clr;
  logic [DW-1:0] in_sum;

  logic          out_valid, out_cout, out_ovf, full, empty, drop_pulse, sticky_ovf;
  logic [DW-1:0] out_sum;
  logic [LW-1:0] level;
  logic [15:0]   ovf_count, drop_count;

  logic          out_valid2, out_cout2, out_ovf2, full2, empty2, drop_pulse2, sticky_ovf2;
  logic [DW-1:0] out_sum2;
  logic [LW-1:0] level2;
  logic [1:0]    ovf_count2, drop_count2;

  always #5 clk = ~clk;

  adder_result_sink #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .in_cout(in_cout),
    .in_ovf(in_ovf), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .level(level), .full(full), .empty(empty),
    .drop_pulse(drop_pulse), .ovf_count(ovf_count), .sticky_ovf(sticky_ovf),
    .stat_clr(stat_clr), .drop_count(drop_count)
  );

  adder_result_sink #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .in_cout(in_cout),
    .in_ovf(in_ovf), .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .out_cout(out_cout2), .out_ovf(out_ovf2), .level(level2), .full(full2), .empty(empty2),
    .drop_pulse(drop_pulse2), .ovf_count(ovf_count2), .sticky_ovf(sticky_ovf2),
    .stat_clr(stat_clr), .drop_count(drop_count2)
  );

  // Reference model: an ordered queue of {sum, cout, ovf} plus unbounded event counts.
  logic [DW+1:0] mq[$];
  int            ovf_n, drop_n;
  logic          m_sticky, m_drop_pulse;
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic int sat(input int n, input int max_val);
    return (n > max_val) ? max_val : n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    ovf_n        = 0;
    drop_n       = 0;
    m_sticky     = 1'b0;
    m_drop_pulse = 1'b0;
  endtask

  task automatic check_all();
    logic [DW+1:0] head;
    int            exp_drop16, exp_drop2;
    head = (mq.size() != 0) ? mq[0] : '0;
`ifdef ADDER_SINK_DROP_CNT_EN
    exp_drop16 = sat(drop_n, 65535);
    exp_drop2  = sat(drop_n, 3);
`else
    exp_drop16 = 0;
    exp_drop2  = 0;
`endif
    check("out_valid",  32'(out_valid),  32'(mq.size() != 0));
    check("out_sum",    32'(out_sum),    32'(head[DW+1:2]));
    check("out_cout",   32'(out_cout),   32'(head[1]));
    check("out_ovf",    32'(out_ovf),    32'(head[0]));
    check("level",      32'(level),      32'(mq.size()));
    check("full",       32'(full),       32'(mq.size() == DEPTH));
    check("empty",      32'(empty),      32'(mq.size() == 0));
    check("drop_pulse", 32'(drop_pulse), 32'(m_drop_pulse));
    check("ovf_count",  32'(ovf_count),  32'(sat(ovf_n, 65535)));
    check("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
    check("drop_count", 32'(drop_count), 32'(exp_drop16));
    check("c2_ovf_count",  32'(ovf_count2),  32'(sat(ovf_n, 3)));
    check("c2_drop_count", 32'(drop_count2), 32'(exp_drop2));
    check("c2_sticky_ovf", 32'(sticky_ovf2), 32'(m_sticky));
    check("c2_head", 32'({out_valid2, out_sum2, out_cout2, out_ovf2}),
          32'({mq.size() != 0, head}));
    check("c2_status", 32'({level2, full2, empty2, drop_pulse2}),
          32'({LW'(mq.size()), mq.size() == DEPTH, mq.size() == 0, m_drop_pulse}));
  endtask

  // One clock of traffic: drive, let the edge happen, advance the model, compare.
  task automatic step(input logic v, input logic [DW-1:0] s, input logic c, input logic o,
                      input logic r, input logic clr);
    bit m_full, m_pop, m_push, m_drop, m_ovf_ev;
    in_valid  = v;
    in_sum    = s;
    in_cout   = c;
    in_ovf    = o;
    out_ready = r;
    stat_clr  = clr;
    m_full   = (mq.size() == DEPTH);
    m_pop    = (mq.size() != 0) && r;
    m_push   = v && (!m_full || m_pop);
    m_drop   = v && m_full && !r;
    m_ovf_ev = m_push && o;
    @(posedge clk);
    if (m_pop)  void'(mq.pop_front());
    if (m_push) mq.push_back({s, c, o});
    if (clr) begin
      ovf_n    = int'(m_ovf_ev);
      m_sticky = m_ovf_ev;
      drop_n   = int'(m_drop);
    end else begin
      ovf_n    = ovf_n + int'(m_ovf_ev);
      m_sticky = m_sticky | m_ovf_ev;
      drop_n   = drop_n + int'(m_drop);
    end
    m_drop_pulse = m_drop;
    #1 check_all();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; in_ovf = 1'b0;
    out_ready = 1'b0; stat_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    rst = 1'b0;

    // First beat falls through after one edge.
    step(1, 8'h7F, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1, 0);

    // Fill, overfill (drop), then a full-FIFO push with simultaneous pop.
    for (int i = 1; i <= 4; i++) step(1, 8'(i), i[0], 0, 0, 0);
    step(1, 8'hAA, 1, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0);
    step(1, 8'h55, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0, 1, 0);

    // Overflow statistics, clear with a coincident event, then a bare clear.
    step(1, 8'h10, 0, 1, 1, 0);
    step(1, 8'h11, 1, 1, 1, 0);
    step(1, 8'h12, 0, 0, 1, 0);
    step(1, 8'h13, 1, 1, 1, 0);
    step(1, 8'h14, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h20 + i), 0, 1, 1, 0);
    step(0, 8'h00, 0, 0, 1, 1);
    step(0, 8'h00, 0, 0, 1, 0);

    // Clear coincident with a drop.
    for (int i = 0; i < 4; i++) step(1, 8'(8'h30 + i), 0, 0, 0, 0);
    step(1, 8'hEE, 0, 1, 0, 1);

    // Reset mid-cycle: contents and stats vanish before the next edge.
    for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 0, 1, 0, 0);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    in_valid = 1'b1; in_sum = 8'h99; in_ovf = 1'b1;
    @(posedge clk);
    #1 check_all();
    rst = 1'b0;
    step(1, 8'h3C, 1, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_result_sink.md
Name: adder_result_sink

Overview:
Receive-side buffer for the adder result interface. It captures each result beat (sum, cout, ovf) that the adder presents with valid_out, which carries no backpressure, into a FIFO. Results are re-presented downstream over a valid/ready handshake. The block keeps overflow statistics and flags any beat lost when the FIFO is full. It sits directly after adder_ip, between the adder and any stalling consumer.

Parameters:
DATA_WIDTH, 32, width of the sum field; must match the upstream adder.
DEPTH, 8, FIFO entries; power of two, ≥2; elaboration $fatal otherwise.
CNT_WIDTH, 16, width of the overflow (and drop) counters; ≥1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  result beat present (driven by adder valid_out).
in_sum  in  DATA_WIDTH  result sum.
in_cout  in  1  result carry-out.
in_ovf  in  1  result overflow flag.
out_valid  out  1  head entry available.
out_ready  in  1  downstream accepts the head entry.
out_sum  out  DATA_WIDTH  head sum.
out_cout  out  1  head carry-out.
out_ovf  out  1  head overflow flag.
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
full  out  1  level == DEPTH.
empty  out  1  level == 0.
drop_pulse  out  1  one-cycle pulse: incoming beat was discarded.
ovf_count  out  CNT_WIDTH  accepted beats with in_ovf=1; saturating.
sticky_ovf  out  1  set by any accepted beat with in_ovf=1.
stat_clr  in  1  synchronous clear of ovf_count, sticky_ovf and drop_count.
drop_count  out  CNT_WIDTH  discarded beats (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): pointers and level 0, out_valid=0, empty=1, full=0, drop_pulse=0, counters 0, sticky_ovf=0. out_sum/out_cout/out_ovf=0.
- Push: in_valid && (!full || (out_ready && out_valid)). A full FIFO accepts a beat in the same cycle the head pops.
- Pop: out_valid && out_ready.
- Drop: in_valid && full && !out_ready. The beat is discarded, drop_pulse=1 on the next cycle only, and the FIFO is unchanged.
- Latency: a beat pushed at edge N is visible on out_* with out_valid=1 after edge N (first-word-fall-through, 1 cycle). No combinational path from in_* to out_*.
- out_* is stable while out_valid && !out_ready. The order of accepted beats is preserved exactly.
- level: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop. Pop with empty cannot occur because out_valid=0.
- Pointers wrap modulo DEPTH. full and empty derive from level.
- ovf_count: +1 per accepted beat with in_ovf=1, saturating at all-ones. Dropped beats never count toward ovf_count.
- stat_clr with a simultaneous counted event: the result is 1 (clear, then apply the event). sticky_ovf follows the same rule.
- Reset mid-operation discards all contents immediately. in_valid during reset is ignored.

Optional Feature:
Macro ADDER_SINK_DROP_CNT_EN.
- Defined: drop_count increments on every drop, saturating at all-ones, and is cleared by stat_clr (clear plus simultaneous drop gives 1).
- Undefined: drop_count is constant 0 and no counter logic is synthesized. drop_pulse behaves identically in both builds.

Decomposition:
- adder_sink_pkg holds: default DEPTH/CNT_WIDTH localparams, a saturating-increment function (width via parameterized class or per-call mask), and reuse of adder_pkg::clog2 for level/pointer widths.
- One sub-module, adder_sink_fifo: storage array, read/write pointers and level, with push/pop/full/empty. Statistics and drop logic live in the top level.

Test Plan:
1. Bench config DATA_WIDTH=8, DEPTH=4, unless noted. Reset, push sum=0x7F/cout=0/ovf=0 with out_ready=0 → next cycle out_valid=1, out_sum=0x7F, level=1, empty=0.
2. With out_ready=0, push 0x01..0x04, then 0xAA → full=1, drop_pulse high exactly 1 cycle, drop_count=1 (macro on) or 0 (off); drain yields 0x01,0x02,0x03,0x04 and never 0xAA.
3. Full FIFO, in_valid=1 with 0x55 and out_ready=1 in the same cycle → 0x01 popped, 0x55 accepted, level stays 4, no drop_pulse; 0x55 emerges last.
4. Accept 3 beats with ovf=1 and 1 with ovf=0 → ovf_count=3, sticky_ovf=1. Then stat_clr=1 with a simultaneous accepted ovf=1 beat → ovf_count=1, sticky_ovf=1.
5. CNT_WIDTH=2: accept 5 ovf=1 beats → ovf_count=3, no wrap. stat_clr alone → 0, sticky_ovf=0.
6. Push 3 beats, assert rst mid-cycle between edges → out_valid=0, empty=1, level=0, counters 0 before the next clk edge. After release, the first push returns the new data only.
